// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared width defaults and FSM state encoding for the sequential divider
package seq_divider_pkg;
    localparam int DW_DEF = 8;
    localparam int VW_DEF = 3;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: request/result bundle between a divider client and the divider
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
);
    logic          start;
    logic [DW-1:0] in_dividend;
    logic [VW-1:0] in_divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] out_q;
    logic [VW-1:0] out_r;
    logic          div_zero;
    modport master (
        output start, in_dividend, in_divisor,
        input  busy, done, out_q, out_r, div_zero
    );
    modport slave (
        input  start, in_dividend, in_divisor,
        output busy, done, out_q, out_r, div_zero
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// div_step: one restoring compare/subtract step on a VW+1-bit partial remainder
module div_step
    import seq_divider_pkg::*;
#(
    parameter int VW = VW_DEF
) (
    input  logic [VW:0]   rem_in,
    input  logic [VW-1:0] divisor,
    output logic [VW-1:0] rem_out,
    output logic          q_bit
);
    logic [VW:0] diff;
    // a clear top bit of the difference means rem_in >= divisor, since rem_in < 2*divisor
    always_comb begin
        diff    = rem_in - {1'b0, divisor};
        q_bit   = ~diff[VW];
        rem_out = q_bit ? diff[VW-1:0] : rem_in[VW-1:0];
    end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: restoring divider producing one quotient bit per clock, MSB first
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int VW = VW_DEF
) (
    input  logic clk,
    input  logic reset_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] LAST = CW'(DW - 1);
    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] dvd;
    logic [VW-1:0] dvs;
    logic [VW-1:0] rem;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
    logic [VW-1:0] rem_nxt;
    logic          q_bit;
    logic [DW-1:0] q_nxt;

    div_step #(.VW(VW)) u_step (
        .rem_in  ({rem, dvd[DW-1]}),
        .divisor (dvs),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    // the dividend register shifts left each step and fills with quotient bits
    assign q_nxt = DW'({dvd, q_bit});

    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.out_q    = q;
    assign bus.out_r    = r;
    assign bus.div_zero = dz;

    // FSM, iteration counter, operand and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            q     <= '0;
            r     <= '0;
            dz    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (!bus.start) begin
                        state <= IDLE;
                    end else if (bus.in_divisor == '0) begin
                        state <= DONE;
                        q     <= '1;
                        r     <= '0;
                        dz    <= 1'b1;
                    end else begin
                        state <= RUN;
                        dvd   <= bus.in_dividend;
                        dvs   <= bus.in_divisor;
                        rem   <= '0;
                        cnt   <= '0;
                        dz    <= 1'b0;
                    end
                end
                RUN: begin
                    dvd <= q_nxt;
                    rem <= rem_nxt;
                    if (cnt == LAST) begin
                        state <= DONE;
                        q     <= q_nxt;
                        r     <= rem_nxt;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and sweep checks of seq_divider against hand-computed results
module tb_seq_divider;
    import seq_divider_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int checks = 0;
    int errors = 0;

    seq_divider_if bus ();

    seq_divider dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [7:0] a, input logic [2:0] b,
                       input logic [7:0] eq, input logic [2:0] er, input logic edz, input int elat);
        int lat;
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_dividend = a;
        bus.in_divisor = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (elat > 0) chk({tag, "_busy"}, bus.busy, 1);
        wait_done(lat);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_q"}, bus.out_q, eq);
        chk({tag, "_r"}, bus.out_r, er);
        chk({tag, "_dz"}, bus.div_zero, edz);
        @(posedge clk);
        #1;
        chk({tag, "_done_low"}, bus.done, 0);
        chk({tag, "_q_hold"}, bus.out_q, eq);
    endtask

    initial begin
        int lat;
        int total;
        logic seen;
        logic [7:0] a;
        logic [2:0] b;
        bus.start = 1'b0;
        bus.in_dividend = '0;
        bus.in_divisor = '0;
        #3 reset_n = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_q", bus.out_q, 0);
        chk("rst_r", bus.out_r, 0);
        chk("rst_dz", bus.div_zero, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run("d200_5", 8'd200, 3'd5, 8'd40, 3'd0, 1'b0, 8);
        run("d255_7", 8'd255, 3'd7, 8'd36, 3'd3, 1'b0, 8);
        run("d0_3", 8'd0, 3'd3, 8'd0, 3'd0, 1'b0, 8);
        run("d7_0", 8'd7, 3'd0, 8'hFF, 3'd0, 1'b1, 0);
        run("d100_3", 8'd100, 3'd3, 8'd33, 3'd1, 1'b0, 8);
        run("d9_1", 8'd9, 3'd1, 8'd9, 3'd0, 1'b0, 8);

        // start pulsed mid-run must be ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_dividend = 8'd100;
        bus.in_divisor = 3'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bus.start = 1'b1;
        bus.in_dividend = 8'd9;
        bus.in_divisor = 3'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat);
        total = lat + 4;
        chk("ign_lat", total, 8);
        chk("ign_q", bus.out_q, 33);
        chk("ign_r", bus.out_r, 1);
        @(posedge clk);
        #1;

        // reset in the middle of a run
        @(negedge clk);
        bus.start = 1'b1;
        bus.in_dividend = 8'd200;
        bus.in_divisor = 3'd7;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        #2 reset_n = 1'b0;
        #1;
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_done", bus.done, 0);
        chk("mrst_q", bus.out_q, 0);
        chk("mrst_r", bus.out_r, 0);
        chk("mrst_dz", bus.div_zero, 0);
        seen = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (12) begin
            @(posedge clk);
            #1;
            seen = seen | bus.done;
        end
        chk("mrst_no_done", seen, 0);
        run("post_rst", 8'd9, 3'd2, 8'd4, 3'd1, 1'b0, 8);

        // exhaustive back-to-back sweep with start held high
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            a = i[10:3];
            b = i[2:0];
            bus.in_dividend = a;
            bus.in_divisor = b;
            @(posedge clk);
            #1;
            wait_done(lat);
            chk("sw_lat", lat, (b == 0) ? 0 : 8);
            chk("sw_q", bus.out_q, (b == 0) ? 8'hFF : a / b);
            chk("sw_r", bus.out_r, (b == 0) ? 3'd0 : 3'(a % b));
            chk("sw_dz", bus.div_zero, (b == 0) ? 1 : 0);
        end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("sw_idle", bus.done | bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL use a single clock domain; reset SHALL be asynchronous and active-low.
REQ-002 Parameter DW, default 8, SHALL set the dividend and quotient width.
REQ-003 Parameter VW, default 3, SHALL set the divisor and remainder width.
REQ-004 Port clk, input, 1, SHALL be the rising-edge clock.
REQ-005 Port reset_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-006 Port start, input, 1, SHALL request a new division.
REQ-007 Port in_dividend, input, DW, SHALL be the dividend, sampled only when start is accepted.
REQ-008 Port in_divisor, input, VW, SHALL be the divisor, sampled only when start is accepted.
REQ-009 Port busy, output, 1, SHALL be high while the state is RUN.
REQ-010 Port done, output, 1, SHALL be a one-cycle pulse marking valid results.
REQ-011 Port out_q, output, DW, SHALL be the quotient.
REQ-012 Port out_r, output, VW, SHALL be the remainder.
REQ-013 Port div_zero, output, 1, SHALL flag that the last accepted divisor was 0.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 Start SHALL be accepted only in IDLE or DONE; start during RUN SHALL be ignored, with no effect on operands or count.
REQ-016 On acceptance with divisor != 0: latch the operands, clear the partial remainder (VW+1 bits) and the iteration counter, clear div_zero, and go to RUN.
REQ-017 Each RUN cycle SHALL perform one restoring step, MSB first.
REQ-018 Restoring step: shift the dividend MSB into the partial remainder; if partial remainder >= divisor, subtract the divisor and shift in quotient bit 1, else shift in 0.
REQ-019 After exactly DW RUN steps the FSM SHALL enter DONE, with out_q and out_r loaded from the final step.
REQ-020 Latency: done SHALL be high during the cycle following the DW-th rising edge after the edge that accepted start (8 cycles at defaults).
REQ-021 done SHALL be high for exactly the single cycle spent in DONE; DONE SHALL go to IDLE, or to RUN if start is high.
REQ-022 On acceptance with divisor == 0: go directly to DONE on the next edge with out_q = all ones, out_r = 0 and div_zero = 1.
REQ-023 out_q, out_r and div_zero SHALL hold their values from DONE until the next DONE entry.
REQ-024 Results SHALL satisfy in_dividend = out_q * in_divisor + out_r, with out_r < in_divisor, for all divisor != 0.
REQ-025 The subtraction SHALL be VW+1 bits wide, so no overflow occurs for any operand pair.

Reset
REQ-026 Asserting reset_n low SHALL immediately force state IDLE, with busy = 0, done = 0, out_q = 0, out_r = 0, div_zero = 0 and counter = 0.
REQ-027 Reset during RUN SHALL abandon the operation; no done pulse SHALL follow.
REQ-028 The first start after reset release SHALL be accepted normally.

Structure
REQ-029 A shared package SHALL hold the DW/VW defaults and the FSM state encoding: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10.
REQ-030 The compare/subtract SHALL be one combinational sub-module, div_step: remainder-in, divisor -> remainder-out, q_bit.
REQ-031 The FSM, counter and registers SHALL reside in seq_divider.

Verification
REQ-032 200 / 5: done 8 cycles after start; out_q = 40, out_r = 0, div_zero = 0.
REQ-033 255 / 7 -> out_q = 36, out_r = 3; then 0 / 3 -> out_q = 0, out_r = 0.
REQ-034 7 / 0 -> done on the next cycle; out_q = 8'hFF, out_r = 0, div_zero = 1; then 100 / 3 -> out_q = 33, out_r = 1, div_zero = 0.
REQ-035 Start 100 / 3, then pulse start with 9 / 2 at RUN cycle 4 -> result stays 33 r 1 and done timing is unchanged.
REQ-036 Assert reset_n low at RUN cycle 5 -> all outputs become 0 asynchronously and no done pulse follows; start 9 / 2 after release -> out_q = 4, out_r = 1.
REQ-037 Assert start held in DONE -> back-to-back operations with no idle cycle; exhaustive 8x3 sweep against a reference model.
